// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// Single-clock first-word-fall-through FIFO: synchronous-read RAM feeding a
// 2-entry register output stage, with level, thresholds, flush and error flags.
module ipml_sync_prefetch_fifo_v2_0 #(
  parameter int c_DATA_WIDTH  = 32,
  parameter int c_DEPTH_WIDTH = 9,
  parameter int c_AF_TH       = (1 << c_DEPTH_WIDTH) - 4,
  parameter int c_AE_TH       = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [c_DATA_WIDTH-1:0]  wr_data,
  input  logic                     wr_en,
  output logic                     wr_vld,
  output logic                     almost_full,
  output logic [c_DATA_WIDTH-1:0]  rd_data,
  input  logic                     rd_en,
  output logic                     rd_vld,
  output logic                     almost_empty,
  output logic [c_DEPTH_WIDTH:0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     err_clr
);

  localparam int                 C       = 1 << c_DEPTH_WIDTH;
  localparam logic [c_DEPTH_WIDTH:0]   cap     = (c_DEPTH_WIDTH+1)'(C);
  localparam logic [c_DEPTH_WIDTH:0]   af_th   = (c_DEPTH_WIDTH+1)'(c_AF_TH);
  localparam logic [c_DEPTH_WIDTH:0]   ae_th   = (c_DEPTH_WIDTH+1)'(c_AE_TH);
  localparam logic [c_DEPTH_WIDTH:0]   cnt_one = 1;
  localparam logic [c_DEPTH_WIDTH-1:0] ptr_one = 1;

  logic [c_DATA_WIDTH-1:0]  mem [0:C-1];
  logic [c_DATA_WIDTH-1:0]  ram_q;

  logic [c_DEPTH_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [c_DEPTH_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [c_DEPTH_WIDTH:0]   ram_cnt_reg, ram_cnt_next;
  logic [c_DEPTH_WIDTH:0]   level_reg, level_next;
  logic                     inflight_reg, inflight_next;
  logic [c_DATA_WIDTH-1:0]  stage0_reg, stage0_next;
  logic [c_DATA_WIDTH-1:0]  stage1_reg, stage1_next;
  logic [1:0]               ost_cnt_reg, ost_cnt_next;
  logic                     af_reg, af_next;
  logic                     ae_reg, ae_next;
  logic                     ovf_reg, ovf_next;
  logic                     unf_reg, unf_next;

  logic       wr_acc, pop, rd_issue;
  logic [1:0] held;

  assign wr_vld = (level_reg != cap);
  assign rd_vld = (ost_cnt_reg != 2'd0);
  assign wr_acc = wr_en & wr_vld & ~flush;
  assign pop    = rd_en & rd_vld & ~flush;
  // Entries held in the output stage plus the one possibly in flight from RAM.
  assign held     = ost_cnt_reg + {1'b0, inflight_reg};
  assign rd_issue = (ram_cnt_reg != '0) & ((held < 2'd2) | pop) & ~flush;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_reg] <= wr_data;
    if (rd_issue) ram_q <= mem[rd_ptr_reg];
  end

  always_comb begin
    wr_ptr_next   = wr_acc ? wr_ptr_reg + ptr_one : wr_ptr_reg;
    rd_ptr_next   = rd_issue ? rd_ptr_reg + ptr_one : rd_ptr_reg;
    ram_cnt_next  = ram_cnt_reg;
    level_next    = level_reg;
    inflight_next = rd_issue;
    stage0_next   = stage0_reg;
    stage1_next   = stage1_reg;
    ost_cnt_next  = ost_cnt_reg;

    case ({wr_acc, rd_issue})
      2'b10:   ram_cnt_next = ram_cnt_reg + cnt_one;
      2'b01:   ram_cnt_next = ram_cnt_reg - cnt_one;
      default: ram_cnt_next = ram_cnt_reg;
    endcase

    case ({wr_acc, pop})
      2'b10:   level_next = level_reg + cnt_one;
      2'b01:   level_next = level_reg - cnt_one;
      default: level_next = level_reg;
    endcase

    // Output stage: pop shifts the head out, a landing RAM word joins the tail.
    case ({pop, inflight_reg})
      2'b11: begin
        if (ost_cnt_reg == 2'd2) begin
          stage0_next = stage1_reg;
          stage1_next = ram_q;
        end else begin
          stage0_next = ram_q;
        end
      end
      2'b10: begin
        stage0_next  = stage1_reg;
        ost_cnt_next = ost_cnt_reg - 2'd1;
      end
      2'b01: begin
        if (ost_cnt_reg == 2'd0) stage0_next = ram_q;
        else stage1_next = ram_q;
        ost_cnt_next = ost_cnt_reg + 2'd1;
      end
      default: ;
    endcase

    if (flush) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      ram_cnt_next  = '0;
      level_next    = '0;
      inflight_next = 1'b0;
      stage0_next   = '0;
      stage1_next   = '0;
      ost_cnt_next  = 2'd0;
    end

    af_next  = (level_next >= af_th);
    ae_next  = (level_next <= ae_th);
    // A new violation wins over err_clr; flush neither sets nor clears.
    ovf_next = (wr_en & ~wr_vld & ~flush) | (ovf_reg & ~err_clr);
    unf_next = (rd_en & ~rd_vld & ~flush) | (unf_reg & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      ram_cnt_reg  <= '0;
      level_reg    <= '0;
      inflight_reg <= 1'b0;
      stage0_reg   <= '0;
      stage1_reg   <= '0;
      ost_cnt_reg  <= 2'd0;
      af_reg       <= 1'b0;
      ae_reg       <= 1'b1;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      ram_cnt_reg  <= ram_cnt_next;
      level_reg    <= level_next;
      inflight_reg <= inflight_next;
      stage0_reg   <= stage0_next;
      stage1_reg   <= stage1_next;
      ost_cnt_reg  <= ost_cnt_next;
      af_reg       <= af_next;
      ae_reg       <= ae_next;
      ovf_reg      <= ovf_next;
      unf_reg      <= unf_next;
    end
  end

  assign rd_data      = stage0_reg;
  assign level        = level_reg;
  assign almost_full  = af_reg;
  assign almost_empty = ae_reg;
  assign overflow     = ovf_reg;
  assign underflow    = unf_reg;

endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// Randomised and directed bench for the prefetch FIFO, checked against a
// queue model where a word is readable two edges after its write.
module tb_ipml_sync_prefetch_fifo_v2_0;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int C  = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst, flush, wr_en, rd_en, err_clr;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_vld, rd_vld, almost_full, almost_empty, overflow, underflow;
  logic [AW:0]   level;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0] mq[$];
  int            mt[$];
  int            edge_n = 0;
  bit            m_ov = 0, m_un = 0;

  ipml_sync_prefetch_fifo_v2_0 #(
    .c_DATA_WIDTH(DW), .c_DEPTH_WIDTH(AW), .c_AF_TH(AF), .c_AE_TH(AE)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_data(wr_data), .wr_en(wr_en),
    .wr_vld(wr_vld), .almost_full(almost_full), .rd_data(rd_data), .rd_en(rd_en),
    .rd_vld(rd_vld), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  function automatic bit m_vld();
    return (mq.size() > 0) && (edge_n - mt[0] >= 2);
  endfunction

  function automatic logic [AW:0] m_lvl();
    return (AW+1)'(mq.size());
  endfunction

  task automatic model_clear();
    mq.delete(); mt.delete(); m_ov = 0; m_un = 0;
  endtask

  // One clock: drive inputs, advance the model on the edge, settle 1ns after it.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
    bit wok, pk;
    wr_en = w; wr_data = d; rd_en = r; flush = f; err_clr = c;
    wok = w && (mq.size() != C);
    pk  = r && m_vld();
    @(posedge clk);
    edge_n++;
    if (f) begin
      mq.delete(); mt.delete();
      if (c) begin m_ov = 0; m_un = 0; end
    end else begin
      if (w && !wok) m_ov = 1; else if (c) m_ov = 0;
      if (r && !pk) m_un = 1; else if (c) m_un = 0;
      if (pk) begin void'(mq.pop_front()); void'(mt.pop_front()); end
      if (wok) begin mq.push_back(d); mt.push_back(edge_n); end
    end
    #1;
    wr_en = 0; rd_en = 0; flush = 0; err_clr = 0;
  endtask

  task automatic test_reset();
    rst = 1; flush = 0; wr_en = 0; rd_en = 0; err_clr = 0; wr_data = '0;
    repeat (3) @(posedge clk);
    #2;
    vectors++; if (wr_vld !== 1'b1) begin miscompares++; $display("FAIL reset_wr_vld got %0b want 1", wr_vld); end
    vectors++; if (rd_vld !== 1'b0) begin miscompares++; $display("FAIL reset_rd_vld got %0b want 0", rd_vld); end
    vectors++; if (rd_data !== '0) begin miscompares++; $display("FAIL reset_rd_data got %h want 0", rd_data); end
    vectors++; if (level !== '0) begin miscompares++; $display("FAIL reset_level got %0d want 0", level); end
    vectors++; if (almost_full !== 1'b0) begin miscompares++; $display("FAIL reset_af got %0b want 0", almost_full); end
    vectors++; if (almost_empty !== 1'b1) begin miscompares++; $display("FAIL reset_ae got %0b want 1", almost_empty); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %0b want 0", overflow); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL reset_unf got %0b want 0", underflow); end
    rst = 0;
    model_clear();
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < C; i++) begin
      step(1, DW'(i), 0, 0, 0);
      vectors++; if (level !== (AW+1)'(i + 1)) begin miscompares++; $display("FAIL fill_level got %0d want %0d", level, i + 1); end
      vectors++; if (wr_vld !== (i != C - 1)) begin miscompares++; $display("FAIL fill_wr_vld got %0b want %0b", wr_vld, i != C - 1); end
    end
    for (int i = 0; i < C; i++) begin
      vectors++; if (rd_vld !== 1'b1 || rd_data !== DW'(i)) begin miscompares++; $display("FAIL drain_data got %0b/%h want 1/%h", rd_vld, rd_data, i); end
      step(0, '0, 1, 0, 0);
    end
    vectors++; if (level !== '0 || rd_vld !== 1'b0) begin miscompares++; $display("FAIL drain_empty got %0d/%0b want 0/0", level, rd_vld); end
  endtask

  task automatic test_latency();
    step(1, 32'hA5, 0, 0, 0);
    vectors++; if (level !== (AW+1)'(1)) begin miscompares++; $display("FAIL lat_level got %0d want 1", level); end
    step(0, '0, 0, 0, 0);
    vectors++; if (rd_vld !== 1'b0) begin miscompares++; $display("FAIL lat_n1 got %0b want 0", rd_vld); end
    step(0, '0, 0, 0, 0);
    vectors++; if (rd_vld !== 1'b1 || rd_data !== 32'hA5) begin miscompares++; $display("FAIL lat_n2 got %0b/%h want 1/a5", rd_vld, rd_data); end
    step(0, '0, 1, 0, 0);
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= C; i++) begin
      step(1, $urandom, 0, 0, 0);
      vectors++; if (almost_full !== (i >= AF) || almost_empty !== (i <= AE)) begin
        miscompares++; $display("FAIL thr_fill lvl %0d af/ae got %0b/%0b want %0b/%0b", i, almost_full, almost_empty, i >= AF, i <= AE); end
    end
    for (int i = C - 1; i >= 0; i--) begin
      vectors++; if (rd_data !== mq[0]) begin miscompares++; $display("FAIL thr_data got %h want %h", rd_data, mq[0]); end
      step(0, '0, 1, 0, 0);
      vectors++; if (level !== (AW+1)'(i) || almost_full !== (i >= AF) || almost_empty !== (i <= AE)) begin
        miscompares++; $display("FAIL thr_drain lvl/af/ae got %0d/%0b/%0b want %0d/%0b/%0b", level, almost_full, almost_empty, i, i >= AF, i <= AE); end
    end
  endtask

  task automatic test_simultaneous();
    logic [DW-1:0] want;
    for (int i = 0; i < 5; i++) step(1, DW'(100 + i), 0, 0, 0);
    repeat (3) step(0, '0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      want = (k < 5) ? DW'(100 + k) : DW'(200 + k - 5);
      vectors++; if (rd_vld !== 1'b1 || rd_data !== want) begin miscompares++; $display("FAIL simul_data got %0b/%h want 1/%h", rd_vld, rd_data, want); end
      step(1, DW'(200 + k), 1, 0, 0);
      vectors++; if (level !== (AW+1)'(5)) begin miscompares++; $display("FAIL simul_level got %0d want 5", level); end
    end
    for (int k = 0; k < 20 && mq.size() > 0; k++) begin
      if (m_vld()) begin
        vectors++; if (rd_data !== mq[0]) begin miscompares++; $display("FAIL simul_tail got %h want %h", rd_data, mq[0]); end
      end
      step(0, '0, 1, 0, 0);
    end
  endtask

  task automatic test_errors();
    for (int i = 0; i < C; i++) step(1, DW'(32'h5000 + i), 0, 0, 0);
    step(1, 32'hDEAD, 0, 0, 0);
    vectors++; if (overflow !== 1'b1 || level !== (AW+1)'(C)) begin miscompares++; $display("FAIL ovf_full got %0b/%0d want 1/%0d", overflow, level, C); end
    step(1, 32'hBEEF, 1, 0, 0);
    vectors++; if (level !== (AW+1)'(C - 1) || overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_rw got %0d/%0b want %0d/1", level, overflow, C - 1); end
    for (int k = 0; k < 2 * C && mq.size() > 0; k++) begin
      if (m_vld()) begin
        vectors++; if (rd_data !== mq[0]) begin miscompares++; $display("FAIL ovf_drain got %h want %h", rd_data, mq[0]); end
      end
      step(0, '0, 1, 0, 0);
    end
    step(0, '0, 1, 0, 0);
    vectors++; if (underflow !== 1'b1) begin miscompares++; $display("FAIL unf_set got %0b want 1", underflow); end
    step(0, '0, 0, 0, 1);
    vectors++; if (overflow !== 1'b0 || underflow !== 1'b0) begin miscompares++; $display("FAIL err_clr got %0b/%0b want 0/0", overflow, underflow); end
    step(0, '0, 1, 0, 1);
    vectors++; if (underflow !== 1'b1 || overflow !== 1'b0) begin miscompares++; $display("FAIL set_wins got %0b/%0b want 1/0", underflow, overflow); end
    step(0, '0, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) step(1, DW'(32'h7000 + i), 0, 0, 0);
    repeat (3) step(0, '0, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    vectors++; if (level !== (AW+1)'(7)) begin miscompares++; $display("FAIL flush_pre got %0d want 7", level); end
    step(1, 32'hFFFF, 1, 1, 0);
    vectors++; if (level !== '0 || rd_vld !== 1'b0 || rd_data !== '0 || wr_vld !== 1'b1) begin
      miscompares++; $display("FAIL flush_out lvl/vld/data/wv got %0d/%0b/%h/%0b want 0/0/0/1", level, rd_vld, rd_data, wr_vld); end
    vectors++; if (almost_full !== 1'b0 || almost_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL flush_flags got %0b%0b%0b%0b want 0100", almost_full, almost_empty, overflow, underflow); end
    step(1, 32'h1234, 0, 0, 0);
    repeat (2) step(0, '0, 0, 0, 0);
    vectors++; if (rd_vld !== 1'b1 || rd_data !== 32'h1234 || level !== (AW+1)'(1)) begin
      miscompares++; $display("FAIL flush_after got %0b/%h/%0d want 1/1234/1", rd_vld, rd_data, level); end
    step(0, '0, 1, 0, 0);
  endtask

  task automatic test_async_reset();
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 6; i++) step(1, $urandom, (i > 3), 0, 0);
    #2 rst = 1;
    #1;
    vectors++; if (wr_vld !== 1'b1 || rd_vld !== 1'b0 || rd_data !== '0 || level !== '0) begin
      miscompares++; $display("FAIL arst_data wv/vld/data/lvl got %0b/%0b/%h/%0d want 1/0/0/0", wr_vld, rd_vld, rd_data, level); end
    vectors++; if (almost_full !== 1'b0 || almost_empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin
      miscompares++; $display("FAIL arst_flags got %0b%0b%0b%0b want 0100", almost_full, almost_empty, overflow, underflow); end
    model_clear();
    @(posedge clk); #3 rst = 0;
  endtask

  task automatic test_random();
    bit w, r, f, c;
    int hi;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      hi = ((cyc / 120) % 2 == 0) ? 1 : 0;
      w = $urandom_range(0, 99) < (hi ? 80 : 30);
      r = $urandom_range(0, 99) < (hi ? 30 : 80);
      f = $urandom_range(0, 199) == 0;
      c = $urandom_range(0, 19) == 0;
      step(w, $urandom, r, f, c);
      vectors++;
      if (level !== m_lvl() || wr_vld !== (mq.size() != C) || rd_vld !== m_vld() ||
          almost_full !== (mq.size() >= AF) || almost_empty !== (mq.size() <= AE) ||
          overflow !== m_ov || underflow !== m_un || (m_vld() && rd_data !== mq[0])) begin
        miscompares++;
        $display("FAIL rand cyc %0d got lvl=%0d wv=%0b rv=%0b d=%h af=%0b ae=%0b ov=%0b un=%0b want lvl=%0d rv=%0b d=%h ov=%0b un=%0b",
                 cyc, level, wr_vld, rd_vld, rd_data, almost_full, almost_empty, overflow, underflow,
                 mq.size(), m_vld(), (mq.size() > 0) ? mq[0] : '0, m_ov, m_un);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_latency();
    test_thresholds();
    test_simultaneous();
    test_errors();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
